// File: rtl/vproc_responder_if.sv
// VProc bus bundle between an initiating node (master) and a memory-mapped target (slave).
interface vproc_responder_if;
    logic [31:0] Addr;
    logic        WE;
    logic        RD;
    logic [31:0] DI;
    logic [31:0] DO;
    logic        WRAck;
    logic        RDAck;
    logic        Irq;

    modport master (output Addr, WE, RD, DI, input DO, WRAck, RDAck, Irq);
    modport slave  (input Addr, WE, RD, DI, output DO, WRAck, RDAck, Irq);
endinterface

// File: rtl/vproc_responder.sv
// VProc bus target: one address segment, word memory plus control registers, programmable wait states.
// Optional periodic interrupt timer is built only when VPROC_RESP_IRQ_EN is defined.
module vproc_responder #(
    parameter int         MEM_AW   = 10,
    parameter logic [3:0] SEG      = 4'ha,
    parameter logic [3:0] WAIT_RST = 4'd0
) (
    input logic               clk,
    input logic               nreset,
    vproc_responder_if.slave  bus
);

    // states: IDLE accept request | WAIT count wait states | ACK access + ack | TURN ignore held strobe
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_TURN = 2'd3;

    logic [1:0]        state;
    logic [3:0]        wcnt;
    logic [3:0]        wait_reg;
    logic [15:0]       count_reg;
    logic [15:0]       reload_reg;
    logic              irq;
    logic              lat_reg;
    logic              lat_we;
    logic              lat_rd;
    logic [MEM_AW-1:0] lat_idx;
    logic [31:0]       lat_data;
    logic [31:0]       do_q;
    logic              wr_ack_q;
    logic              rd_ack_q;
    logic [31:0]       rd_data;
    logic              req;
    logic              do_access;
    logic              reg_wr;
    logic              unused_addr;

    logic [31:0] mem [2**MEM_AW];

    assign req         = (bus.Addr[31:28] == SEG) && (bus.WE || bus.RD);
    assign do_access   = (state == ST_ACK);
    assign reg_wr      = do_access && lat_we && lat_reg;
    assign unused_addr = ^bus.Addr[26:MEM_AW];

    always_comb begin
        rd_data = '0;
        if (!lat_reg) begin
            rd_data = mem[lat_idx];
        end else begin
            case (lat_idx[1:0])
                2'd0:    rd_data = {28'd0, wait_reg};
                2'd1:    rd_data = {16'd0, count_reg};
                2'd2:    rd_data = {16'd0, reload_reg};
                default: rd_data = {31'd0, irq};
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            wcnt      <= '0;
            lat_reg   <= 1'b0;
            lat_we    <= 1'b0;
            lat_rd    <= 1'b0;
            lat_idx   <= '0;
            lat_data  <= '0;
            do_q      <= '0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            wait_reg  <= WAIT_RST;
            count_reg <= '0;
        end else begin
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        lat_reg  <= bus.Addr[27];
                        lat_idx  <= bus.Addr[MEM_AW-1:0];
                        lat_data <= bus.DI;
                        lat_we   <= bus.WE;
                        lat_rd   <= bus.RD;
                        wcnt     <= wait_reg;
                        state    <= (wait_reg != 4'd0) ? ST_WAIT : ST_ACK;
                    end
                end
                ST_WAIT: begin
                    wcnt <= wcnt - 4'd1;
                    if (wcnt == 4'd1) state <= ST_ACK;
                end
                ST_ACK: begin
                    wr_ack_q  <= lat_we;
                    rd_ack_q  <= lat_rd;
                    // rd_data sees pre-write contents, so a combined WE/RD returns the old value
                    if (lat_rd) do_q <= rd_data;
                    count_reg <= count_reg + 16'd1;
                    if (reg_wr && lat_idx[1:0] == 2'd0) wait_reg <= lat_data[3:0];
                    state     <= ST_TURN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_access && lat_we && !lat_reg) mem[lat_idx] <= lat_data;
    end

`ifdef VPROC_RESP_IRQ_EN
    logic [15:0] tmr;
    logic        expire;
    logic        irq_clr;

    assign expire  = (tmr == 16'd1) && (reload_reg != 16'd0);
    assign irq_clr = reg_wr && (lat_idx[1:0] == 2'd3);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            reload_reg <= '0;
            tmr        <= '0;
            irq        <= 1'b0;
        end else begin
            if (reg_wr && lat_idx[1:0] == 2'd2) reload_reg <= lat_data[15:0];
            if (reload_reg == 16'd0)                  tmr <= '0;
            else if (tmr == 16'd0 || tmr == 16'd1)    tmr <= reload_reg;
            else                                      tmr <= tmr - 16'd1;
            // expiry wins over a simultaneous clear
            if (expire)       irq <= 1'b1;
            else if (irq_clr) irq <= 1'b0;
        end
    end
`else
    assign reload_reg = '0;
    assign irq        = 1'b0;
`endif

    assign bus.DO    = do_q;
    assign bus.WRAck = wr_ack_q;
    assign bus.RDAck = rd_ack_q;
    assign bus.Irq   = irq;

endmodule

// File: tb/tb_vproc_responder.sv
// Directed bench for vproc_responder: transaction-level model plus per-cycle output compare.
module tb_vproc_responder;

    logic clk    = 1'b0;
    logic nreset = 1'b1;

    vproc_responder_if bus ();

    vproc_responder #(.MEM_AW(10), .SEG(4'ha), .WAIT_RST(4'd0)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] mem_m [int];
    logic [3:0]  m_wait;
    logic [15:0] m_count;
    logic [15:0] m_reload;
    int          reload_edge;
    int          clr_edge;
    int          ack_cyc = -1;
    logic        exp_wr, exp_rd;
    logic [31:0] pend_do;
    logic [31:0] cur_do;
    bit          run = 0;
    bit          hit;

    int          last_lat;
    int          seen_cyc;
    logic [31:0] last_do;
    logic [1:0]  last_acks;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Timer fires R cycles after the RELOAD write takes effect plus one load cycle, then every R cycles.
    function automatic logic irq_exp(input int c);
        int r;
        int f;
        r = int'(m_reload);
        if (r == 0 || c < reload_edge + 1 + r) return 1'b0;
        f = reload_edge + 1 + r * ((c - reload_edge - 1) / r);
        return (f >= clr_edge);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int c);
        if (!a[27]) return mem_m.exists(int'(a[9:0])) ? mem_m[int'(a[9:0])] : 32'h0;
        case (a[1:0])
            2'd0:    return {28'd0, m_wait};
            2'd1:    return {16'd0, m_count};
            2'd2:    return {16'd0, m_reload};
            default: return {31'd0, irq_exp(c - 1)};
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int c);
        if (!a[27]) mem_m[int'(a[9:0])] = d;
        else begin
            case (a[1:0])
                2'd0: m_wait = d[3:0];
`ifdef VPROC_RESP_IRQ_EN
                2'd2: begin m_reload = d[15:0]; reload_edge = c; end
`endif
                2'd3: clr_edge = c;
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        ack_cyc     = -1;
        cur_do      = '0;
        m_wait      = 4'd0;
        m_count     = '0;
        m_reload    = '0;
        reload_edge = 0;
        clr_edge    = 0;
    endtask

    // Called at a falling edge; returns at a later falling edge with strobes dropped.
    task automatic access(input logic [31:0] a, input logic we, input logic rd, input logic [31:0] d);
        int k;
        bit seen;
        bus.Addr = a;
        bus.WE   = we;
        bus.RD   = rd;
        bus.DI   = d;
        k        = cyc;
        exp_wr   = we;
        exp_rd   = rd;
        ack_cyc  = k + 2 + int'(m_wait);
        pend_do  = model_read(a, ack_cyc);
        if (we) model_write(a, d, ack_cyc);
        m_count  = m_count + 16'd1;
        seen     = 0;
        seen_cyc = k;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (bus.WRAck || bus.RDAck) begin
                seen      = 1;
                seen_cyc  = cyc;
                last_do   = bus.DO;
                last_acks = {bus.WRAck, bus.RDAck};
            end
        end
        chk("ack_seen", {31'd0, seen}, 32'd1);
        last_lat = seen_cyc - (k + 1);
        @(negedge clk);
        bus.WE = 1'b0;
        bus.RD = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (run) begin
                hit = (cyc == ack_cyc);
                if (hit && exp_rd) cur_do = pend_do;
                chk("WRAck", {31'd0, bus.WRAck}, {31'd0, hit && exp_wr});
                chk("RDAck", {31'd0, bus.RDAck}, {31'd0, hit && exp_rd});
                chk("DO", bus.DO, cur_do);
                chk("Irq", {31'd0, bus.Irq}, {31'd0, irq_exp(cyc)});
            end
        end
    end

    initial begin
        int stray;
        int e_cyc;
        int rise1;
        int rise2;
        bus.Addr = '0;
        bus.WE   = 1'b0;
        bus.RD   = 1'b0;
        bus.DI   = '0;
        #3;
        nreset = 1'b0;
        model_reset();
        run = 1;
        repeat (3) @(negedge clk);
        chk("rst_DO", bus.DO, 32'h0);
        chk("rst_acks", {30'd0, bus.WRAck, bus.RDAck}, 32'h0);
        nreset = 1'b1;

        access(32'hA000_0004, 1, 0, 32'hDEAD_BEEF);
        chk("w0_lat", last_lat, 1);
        access(32'hA000_0004, 0, 1, 32'h0);
        chk("r0_lat", last_lat, 1);
        chk("r0_data", last_do, 32'hDEAD_BEEF);
        access(32'hA800_0001, 0, 1, 32'h0);
        chk("count_a", last_do, 32'd2);
        access(32'hA800_0001, 0, 1, 32'h0);
        chk("count_b", last_do, 32'd3);

        access(32'hA000_0010, 1, 0, 32'h55AA_1234);
        access(32'hA800_0000, 1, 0, 32'd5);
        access(32'hA000_0010, 0, 1, 32'h0);
        chk("wait5_lat", last_lat, 6);
        chk("wait5_data", last_do, 32'h55AA_1234);
        access(32'hA800_0000, 1, 0, 32'h1F);
        access(32'hA800_0000, 0, 1, 32'h0);
        chk("wait_mask", last_do, 32'hF);

        bus.Addr = 32'hB000_0000;
        bus.RD   = 1'b1;
        stray    = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (bus.WRAck || bus.RDAck) stray++;
        end
        chk("unsel_acks", stray, 0);
        @(negedge clk);
        bus.RD = 1'b0;
        access(32'hA800_0001, 0, 1, 32'h0);
        chk("unsel_count", last_do, 32'd9);
        chk("wait15_lat", last_lat, 16);
        access(32'hA800_0001, 1, 0, 32'hFFFF);
        access(32'hA800_0001, 0, 1, 32'h0);
        chk("count_ro", last_do, 32'd11);

        access(32'hA800_0000, 1, 0, 32'd8);
        access(32'hA000_0020, 1, 0, 32'h0BAD_F00D);
        bus.Addr = 32'hA000_0020;
        bus.DI   = 32'h1234_5678;
        bus.WE   = 1'b1;
        repeat (4) @(negedge clk);
        nreset = 1'b0;
        bus.WE = 1'b0;
        model_reset();
        #2;
        chk("abort_do", bus.DO, 32'h0);
        chk("abort_ack", {31'd0, bus.WRAck}, 32'h0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        access(32'hA000_0020, 0, 1, 32'h0);
        chk("abort_lat", last_lat, 1);
        chk("abort_mem", last_do, 32'h0BAD_F00D);
        access(32'hA800_0000, 0, 1, 32'h0);
        chk("abort_wait", last_do, 32'h0);

        access(32'hA000_0008, 1, 0, 32'h11);
        access(32'hA000_0008, 1, 1, 32'h22);
        chk("both_acks", {30'd0, last_acks}, 32'd3);
        chk("both_do", last_do, 32'h11);
        access(32'hA000_0008, 0, 1, 32'h0);
        chk("both_new", last_do, 32'h22);

`ifdef VPROC_RESP_IRQ_EN
        access(32'hA800_0002, 1, 0, 32'd10);
        e_cyc = seen_cyc;
        rise1 = -1000;
        for (int i = 0; i < 30 && rise1 < 0; i++) begin
            @(negedge clk);
            #2;
            if (bus.Irq) rise1 = cyc;
        end
        chk("irq_first", rise1 - e_cyc, 11);
        access(32'hA800_0003, 1, 0, 32'h0);
        chk("irq_clr", {31'd0, bus.Irq}, 32'h0);
        rise2 = -1000;
        for (int i = 0; i < 20 && rise2 < 0; i++) begin
            @(negedge clk);
            #2;
            if (bus.Irq) rise2 = cyc;
        end
        chk("irq_period", rise2 - rise1, 10);
        access(32'hA800_0003, 0, 1, 32'h0);
        chk("irqclr_rd", last_do, 32'd1);
        access(32'hA800_0002, 0, 1, 32'h0);
        chk("reload_rd", last_do, 32'd10);
`else
        e_cyc = 0;
        rise1 = 0;
        rise2 = 0;
        access(32'hA800_0002, 1, 0, 32'd10);
        repeat (40) @(negedge clk);
        chk("irq_off", {31'd0, bus.Irq}, 32'h0);
        access(32'hA800_0002, 0, 1, 32'h0);
        chk("reload_off", last_do, 32'h0);
        access(32'hA800_0003, 0, 1, 32'h0);
        chk("irqclr_off", last_do, 32'h0);
`endif
        repeat (5) @(negedge clk);
        run = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
